// File: rtl/cnn_host_link.sv
// Framed UART host protocol: sync/header/payload/checksum receiver feeding the ifmap buffer,
// plus a queued result/error reply transmitter. Define CNN_HOST_LOGIT_EN to append the logit to result replies.
module cnn_host_link #(
  parameter int         IMG_SIZE       = 28,
  parameter int         IN_CHANNELS    = 1,
  parameter int         DATA_WIDTH     = 16,
  parameter int         FRAC_BITS      = 7,
  parameter int         PIXEL_BYTES    = 1,
  parameter int         NUM_CLASSES    = 10,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  localparam int        IDXW           = $clog2(NUM_CLASSES),
  localparam int        ADDRW          = $clog2(IN_CHANNELS*IMG_SIZE*IMG_SIZE),
  localparam int        CHW            = $clog2(IN_CHANNELS+1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  input  logic                  tx_busy,
  output logic                  wr_en,
  output logic [ADDRW-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_loaded,
  output logic [CHW-1:0]        frame_channels,
  output logic                  frame_error,
  input  logic                  result_valid,
  input  logic [IDXW-1:0]       result_idx,
  input  logic [DATA_WIDTH-1:0] result_logit,
  output logic                  link_busy
);

  localparam int         PIX_PER_CH = IMG_SIZE*IMG_SIZE;
  localparam int         CNTW       = $clog2(IN_CHANNELS*PIX_PER_CH+1);
  localparam int         TMOW       = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [7:0] MAX_CH     = 8'(IN_CHANNELS);
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT_CYCLES-1);
`ifdef CNN_HOST_LOGIT_EN
  localparam logic [2:0] RES_LAST   = 3'd3;
`else
  localparam logic [2:0] RES_LAST   = 3'd1;
`endif
  localparam logic [2:0] ERR_LAST   = 3'd1;

  typedef enum logic [1:0] {R_IDLE, R_HDR, R_PAYLOAD, R_CSUM} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

  rx_state_t             r_rxState, w_rxNext;
  logic [CHW-1:0]        r_chans, w_chansNext;
  logic [7:0]            r_csum, w_csumNext;
  logic [CNTW-1:0]       r_pixCnt, w_pixCntNext;
  logic                  r_phase, w_phaseNext;
  logic [7:0]            r_msb, w_msbNext;
  logic [TMOW-1:0]       r_tmo, w_tmoNext;
  logic                  r_wrEn, w_wrEnNext;
  logic [ADDRW-1:0]      r_wrAddr, w_wrAddrNext;
  logic [DATA_WIDTH-1:0] r_wrData, w_wrDataNext;
  logic                  r_frameLoaded, w_loadedNext;
  logic [CHW-1:0]        r_frameChannels, w_chanOutNext;
  logic                  r_frameError, w_errorNext;
  logic                  r_linkBusy;

  logic                  w_rxAccept;
  logic [CNTW-1:0]       w_total;
  logic [CNTW-1:0]       w_pixInc;
  logic [DATA_WIDTH-1:0] w_pix8;
  logic signed [15:0]    w_raw16;
  logic [DATA_WIDTH-1:0] w_pix16;

  // Bytes are ignored entirely while a result is outstanding for the last good frame.
  assign w_rxAccept = rx_dv & ~r_linkBusy;
  assign w_total    = CNTW'(r_chans) * CNTW'(PIX_PER_CH);
  assign w_pixInc   = r_pixCnt + 1'b1;
  assign w_pix8     = DATA_WIDTH'(rx_byte) << FRAC_BITS;
  assign w_raw16    = {r_msb, rx_byte};
  assign w_pix16    = DATA_WIDTH'(w_raw16);

  always_comb begin
    w_rxNext      = r_rxState;
    w_chansNext   = r_chans;
    w_csumNext    = r_csum;
    w_pixCntNext  = r_pixCnt;
    w_phaseNext   = r_phase;
    w_msbNext     = r_msb;
    w_tmoNext     = '0;
    w_wrEnNext    = 1'b0;
    w_wrAddrNext  = r_wrAddr;
    w_wrDataNext  = r_wrData;
    w_loadedNext  = 1'b0;
    w_chanOutNext = r_frameChannels;
    w_errorNext   = 1'b0;
    if (r_rxState != R_IDLE && !w_rxAccept) begin
      if (r_tmo == TMO_LAST) begin
        w_errorNext = 1'b1;
        w_rxNext    = R_IDLE;
      end else begin
        w_tmoNext = r_tmo + 1'b1;
      end
    end
    if (w_rxAccept) begin
      case (r_rxState)
        R_IDLE: begin
          if (rx_byte == SYNC_BYTE) w_rxNext = R_HDR;
        end
        R_HDR: begin
          if (rx_byte != 8'h00 && rx_byte <= MAX_CH) begin
            w_chansNext  = CHW'(rx_byte);
            w_csumNext   = 8'h00;
            w_pixCntNext = '0;
            w_phaseNext  = 1'b0;
            w_rxNext     = R_PAYLOAD;
          end else begin
            w_errorNext = 1'b1;
            w_rxNext    = R_IDLE;
          end
        end
        R_PAYLOAD: begin
          w_csumNext = r_csum ^ rx_byte;
          if (PIXEL_BYTES == 2 && !r_phase) begin
            w_phaseNext = 1'b1;
            w_msbNext   = rx_byte;
          end else begin
            w_phaseNext  = 1'b0;
            w_wrEnNext   = 1'b1;
            w_wrAddrNext = r_pixCnt[ADDRW-1:0];
            w_wrDataNext = (PIXEL_BYTES == 2) ? w_pix16 : w_pix8;
            w_pixCntNext = w_pixInc;
            if (w_pixInc == w_total) w_rxNext = R_CSUM;
          end
        end
        R_CSUM: begin
          if (rx_byte == r_csum) begin
            w_loadedNext  = 1'b1;
            w_chanOutNext = r_chans;
          end else begin
            w_errorNext = 1'b1;
          end
          w_rxNext = R_IDLE;
        end
        default: w_rxNext = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxState       <= R_IDLE;
      r_chans         <= '0;
      r_csum          <= '0;
      r_pixCnt        <= '0;
      r_phase         <= 1'b0;
      r_msb           <= '0;
      r_tmo           <= '0;
      r_wrEn          <= 1'b0;
      r_wrAddr        <= '0;
      r_wrData        <= '0;
      r_frameLoaded   <= 1'b0;
      r_frameChannels <= '0;
      r_frameError    <= 1'b0;
    end else begin
      r_rxState       <= w_rxNext;
      r_chans         <= w_chansNext;
      r_csum          <= w_csumNext;
      r_pixCnt        <= w_pixCntNext;
      r_phase         <= w_phaseNext;
      r_msb           <= w_msbNext;
      r_tmo           <= w_tmoNext;
      r_wrEn          <= w_wrEnNext;
      r_wrAddr        <= w_wrAddrNext;
      r_wrData        <= w_wrDataNext;
      r_frameLoaded   <= w_loadedNext;
      r_frameChannels <= w_chanOutNext;
      r_frameError    <= w_errorNext;
    end
  end

  tx_state_t      r_txState, w_txNext;
  logic [7:0]     r_txByte, w_txByteNext;
  logic           r_resPend, r_errPend;
  logic [IDXW-1:0] r_resIdx;
  logic           r_curIsRes, w_curIsResNext;
  logic [2:0]     r_byteIdx, w_byteIdxNext;
  logic [2:0]     w_idxInc;
  logic           r_waitSkip, w_waitSkipNext;
  logic           w_startRes, w_startErr, w_resDone;
  logic [7:0]     w_digit;
  logic [7:0]     w_nextByte;

  assign w_digit  = 8'h30 + 8'(r_resIdx);
  assign w_idxInc = r_byteIdx + 1'b1;

`ifdef CNN_HOST_LOGIT_EN
  logic [15:0] r_resLogit;
  logic [15:0] r_txLogit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resLogit <= '0;
      r_txLogit  <= '0;
    end else begin
      if (result_valid) r_resLogit <= 16'($signed(result_logit));
      if (w_startRes)   r_txLogit  <= r_resLogit;
    end
  end

  always_comb begin
    w_nextByte = 8'h0A;
    if (r_curIsRes) begin
      case (w_idxInc)
        3'd1:    w_nextByte = r_txLogit[15:8];
        3'd2:    w_nextByte = r_txLogit[7:0];
        default: w_nextByte = 8'h0A;
      endcase
    end
  end
`else
  logic w_unusedLogit;
  assign w_unusedLogit = ^result_logit;
  assign w_nextByte    = 8'h0A;
`endif

  // Result replies win over error replies when both are pending.
  always_comb begin
    w_txNext       = r_txState;
    w_txByteNext   = r_txByte;
    w_curIsResNext = r_curIsRes;
    w_byteIdxNext  = r_byteIdx;
    w_waitSkipNext = r_waitSkip;
    w_startRes     = 1'b0;
    w_startErr     = 1'b0;
    w_resDone      = 1'b0;
    case (r_txState)
      T_IDLE: begin
        if (!tx_busy && (r_resPend || r_errPend)) begin
          w_txNext      = T_SEND;
          w_byteIdxNext = 3'd0;
          if (r_resPend) begin
            w_startRes     = 1'b1;
            w_curIsResNext = 1'b1;
            w_txByteNext   = w_digit;
          end else begin
            w_startErr     = 1'b1;
            w_curIsResNext = 1'b0;
            w_txByteNext   = 8'h45;
          end
        end
      end
      T_SEND: begin
        w_txNext       = T_WAIT;
        w_waitSkipNext = 1'b1;
      end
      T_WAIT: begin
        if (r_waitSkip) begin
          w_waitSkipNext = 1'b0;
        end else if (!tx_busy) begin
          if (r_byteIdx == (r_curIsRes ? RES_LAST : ERR_LAST)) begin
            w_txNext  = T_IDLE;
            w_resDone = r_curIsRes;
          end else begin
            w_txNext      = T_SEND;
            w_byteIdxNext = w_idxInc;
            w_txByteNext  = w_nextByte;
          end
        end
      end
      default: w_txNext = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_txState  <= T_IDLE;
      r_txByte   <= '0;
      r_curIsRes <= 1'b0;
      r_byteIdx  <= '0;
      r_waitSkip <= 1'b0;
      r_resPend  <= 1'b0;
      r_errPend  <= 1'b0;
      r_resIdx   <= '0;
    end else begin
      r_txState  <= w_txNext;
      r_txByte   <= w_txByteNext;
      r_curIsRes <= w_curIsResNext;
      r_byteIdx  <= w_byteIdxNext;
      r_waitSkip <= w_waitSkipNext;
      if (result_valid) begin
        r_resPend <= 1'b1;
        r_resIdx  <= result_idx;
      end else if (w_startRes) begin
        r_resPend <= 1'b0;
      end
      if (r_frameError)    r_errPend <= 1'b1;
      else if (w_startErr) r_errPend <= 1'b0;
    end
  end

  // No timeout on the busy lock: only a reset recovers a frame whose result never arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_linkBusy <= 1'b0;
    else if (w_loadedNext) r_linkBusy <= 1'b1;
    else if (w_resDone)    r_linkBusy <= 1'b0;
  end

  assign tx_dv          = (r_txState == T_SEND);
  assign tx_byte        = r_txByte;
  assign wr_en          = r_wrEn;
  assign wr_addr        = r_wrAddr;
  assign wr_data        = r_wrData;
  assign frame_loaded   = r_frameLoaded;
  assign frame_channels = r_frameChannels;
  assign frame_error    = r_frameError;
  assign link_busy      = r_linkBusy;

endmodule
